idx_to_oh_skid: RTL and testbench

Registered binary-to-one-hot decoder with a valid/ready handshake on both sides and a two-entry skid buffer. It turns a NoC destination or port index into a one-hot select vector for a crossbar or demux stage, matching the LSB0/MSB0 bit ordering used by the codebase's one-hot-to-index encoder. The two-entry buffer lets it run at full throughput with no combinational path from `out_ready` to `in_ready`.

---
 rtl/idx_to_oh_skid.sv | 109 ++++++++++
 tb/tb_idx_to_oh_skid.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/idx_to_oh_skid.sv
// Registered binary-index to one-hot decoder with valid/ready handshake.
// A main register drives the outputs; a skid register absorbs one beat so in_ready is flop-driven.
module idx_to_oh_skid #(
   parameter int NUM_SIGNALS = 4,
   parameter     DIRECTION   = "LSB0",
   parameter int INDEX_WIDTH = $clog2(NUM_SIGNALS)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INDEX_WIDTH-1:0] in_index,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [NUM_SIGNALS-1:0] out_one_hot,
   output logic                   out_err
);

   localparam bit                   IS_MSB0   = (DIRECTION == "MSB0");
   localparam logic [INDEX_WIDTH:0]   N_EXT     = (INDEX_WIDTH+1)'(NUM_SIGNALS);
   localparam logic [INDEX_WIDTH-1:0] N_MINUS_1 = INDEX_WIDTH'(NUM_SIGNALS - 1);

   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_ONE   = 2'b10;
   localparam logic [1:0] ST_TWO   = 2'b11;

   logic                   r_main_valid;
   logic                   r_skid_valid;
   logic [NUM_SIGNALS-1:0] r_main_oh;
   logic                   r_main_err;
   logic [NUM_SIGNALS-1:0] r_skid_oh;
   logic                   r_skid_err;

   logic [INDEX_WIDTH-1:0] w_pos;
   logic [NUM_SIGNALS-1:0] w_one_hot;
   logic                   w_err;
   logic                   w_in_fire;
   logic                   w_out_fire;

   // MSB0 mirrors the index at INDEX_WIDTH width: (N-1) - idx == N - idx - 1.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      w_one_hot = '0;
      w_err     = 1'b0;
      w_pos     = IS_MSB0 ? (N_MINUS_1 - in_index) : in_index;
      if ({1'b0, in_index} >= N_EXT) begin
         w_err = 1'b1;
      end else begin
         for (int i = 0; i < NUM_SIGNALS; i++) begin
            w_one_hot[i] = (w_pos == INDEX_WIDTH'(i));
         end
      end
   end

   assign w_in_fire  = in_valid & ~r_skid_valid;
   assign w_out_fire = r_main_valid & out_ready;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   // NOTE: data registers are reset too, because the main register drives out_one_hot/out_err directly.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_main_oh    <= '0;
         r_main_err   <= 1'b0;
         r_skid_oh    <= '0;
         r_skid_err   <= 1'b0;
      end else begin
         case ({r_main_valid, r_skid_valid})
            ST_EMPTY: begin
               if (w_in_fire) begin
                  r_main_valid <= 1'b1;
                  r_main_oh    <= w_one_hot;
                  r_main_err   <= w_err;
               end
            end
            ST_ONE: begin
               if (w_in_fire && w_out_fire) begin
                  r_main_oh  <= w_one_hot;
                  r_main_err <= w_err;
               end else if (w_in_fire) begin
                  r_skid_valid <= 1'b1;
                  r_skid_oh    <= w_one_hot;
                  r_skid_err   <= w_err;
               end else if (w_out_fire) begin
                  r_main_valid <= 1'b0;
               end
            end
            ST_TWO: begin
               if (w_out_fire) begin
                  r_skid_valid <= 1'b0;
                  r_main_oh    <= r_skid_oh;
                  r_main_err   <= r_skid_err;
               end
            end
            default: begin
               r_main_valid <= 1'b0;
               r_skid_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = ~r_skid_valid;
   assign out_valid   = r_main_valid;
   assign out_one_hot = r_main_oh;
   assign out_err     = r_main_err;

endmodule

// File: tb/tb_idx_to_oh_skid.sv
// Directed bench for idx_to_oh_skid: LSB0/MSB0 decode, backpressure, out-of-range,
// async reset while full, and a short scoreboarded soak.
module tb_idx_to_oh_skid;

   logic clk;
   logic reset_n;

   // N=4 LSB0
   logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
   logic [1:0] a_in_index;
   logic [3:0] a_out_one_hot;
   // N=4 MSB0
   logic       m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_out_err;
   logic [1:0] m_in_index;
   logic [3:0] m_out_one_hot;
   // N=5 LSB0
   logic       f_in_valid, f_in_ready, f_out_valid, f_out_ready, f_out_err;
   logic [2:0] f_in_index;
   logic [4:0] f_out_one_hot;

   int checks;
   int failures;

   idx_to_oh_skid #(.NUM_SIGNALS(4), .DIRECTION("LSB0")) u_a (
      .clk(clk), .reset_n(reset_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_index(a_in_index),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_one_hot(a_out_one_hot), .out_err(a_out_err)
   );

   idx_to_oh_skid #(.NUM_SIGNALS(4), .DIRECTION("MSB0")) u_m (
      .clk(clk), .reset_n(reset_n),
      .in_valid(m_in_valid), .in_ready(m_in_ready), .in_index(m_in_index),
      .out_valid(m_out_valid), .out_ready(m_out_ready),
      .out_one_hot(m_out_one_hot), .out_err(m_out_err)
   );

   idx_to_oh_skid #(.NUM_SIGNALS(5), .DIRECTION("LSB0")) u_f (
      .clk(clk), .reset_n(reset_n),
      .in_valid(f_in_valid), .in_ready(f_in_ready), .in_index(f_in_index),
      .out_valid(f_out_valid), .out_ready(f_out_ready),
      .out_one_hot(f_out_one_hot), .out_err(f_out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle just after it, so checks never race the clock.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] q_exp[$];
   logic [3:0] w_push;
   logic [3:0] held_oh;
   logic       stalled;

   initial begin
      checks   = 0;
      failures = 0;
      reset_n  = 1'b1;
      {a_in_valid, a_out_ready, m_in_valid, m_out_ready, f_in_valid, f_out_ready} = '0;
      a_in_index = '0; m_in_index = '0; f_in_index = '0;
      #1 reset_n = 1'b0;
      #2;
      check("rst_out_valid", a_out_valid, 0);
      check("rst_in_ready",  a_in_ready, 1);
      check("rst_one_hot",   a_out_one_hot, 0);
      check("rst_err",       a_out_err, 0);
      repeat (2) tick();
      reset_n = 1'b1;
      tick();

      // LSB0 back-to-back stream
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      a_in_index = 2'd0; tick();
      check("lsb0_v0", a_out_valid, 1);
      check("lsb0_i0", a_out_one_hot, 4'b0001);
      a_in_index = 2'd1; tick();
      check("lsb0_i1", a_out_one_hot, 4'b0010);
      a_in_index = 2'd2; tick();
      check("lsb0_i2", a_out_one_hot, 4'b0100);
      a_in_index = 2'd3; tick();
      check("lsb0_i3", a_out_one_hot, 4'b1000);
      check("lsb0_err", a_out_err, 0);
      a_in_valid = 1'b0; tick();
      check("lsb0_drain", a_out_valid, 0);

      // MSB0 decode
      m_out_ready = 1'b1;
      m_in_valid  = 1'b1;
      m_in_index = 2'd0; tick();
      check("msb0_i0", m_out_one_hot, 4'b1000);
      m_in_index = 2'd3; tick();
      check("msb0_i3", m_out_one_hot, 4'b0001);
      m_in_valid = 1'b0; tick();
      check("msb0_drain", m_out_valid, 0);

      // Backpressure: three stalled cycles, then release
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_index  = 2'd1; tick();
      check("bp_hold1", a_out_one_hot, 4'b0010);
      check("bp_rdy1",  a_in_ready, 1);
      a_in_index = 2'd2; tick();
      check("bp_hold2", a_out_one_hot, 4'b0010);
      check("bp_rdy2",  a_in_ready, 0);
      a_in_index = 2'd3; tick();
      check("bp_hold3", a_out_one_hot, 4'b0010);
      check("bp_rdy3",  a_in_ready, 0);
      a_out_ready = 1'b1; tick();
      check("bp_rel2", a_out_one_hot, 4'b0100);
      check("bp_rdy4", a_in_ready, 1);
      tick();
      check("bp_rel3", a_out_one_hot, 4'b1000);
      check("bp_v3",   a_out_valid, 1);
      a_in_valid = 1'b0; tick();
      check("bp_drain", a_out_valid, 0);

      // Out-of-range on N=5
      f_out_ready = 1'b1;
      f_in_valid  = 1'b1;
      f_in_index = 3'd6; tick();
      check("oor_v",   f_out_valid, 1);
      check("oor_oh",  f_out_one_hot, 5'b00000);
      check("oor_err", f_out_err, 1);
      f_in_index = 3'd4; tick();
      check("n5_i4_oh",  f_out_one_hot, 5'b10000);
      check("n5_i4_err", f_out_err, 0);
      f_in_valid = 1'b0; tick();
      check("n5_drain", f_out_valid, 0);

      // Async reset while full
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_index = 2'd0; tick();
      a_in_index = 2'd1; tick();
      check("two_rdy", a_in_ready, 0);
      check("two_v",   a_out_valid, 1);
      a_in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check("arst_v",   a_out_valid, 0);
      check("arst_rdy", a_in_ready, 1);
      check("arst_oh",  a_out_one_hot, 0);
      #1 reset_n = 1'b1;
      tick();
      a_out_ready = 1'b1;
      tick();
      check("arst_empty", a_out_valid, 0);
      a_in_valid = 1'b1;
      a_in_index = 2'd2; tick();
      check("arst_beat", a_out_one_hot, 4'b0100);
      check("arst_bv",   a_out_valid, 1);
      a_in_valid = 1'b0; tick();
      check("arst_only", a_out_valid, 0);

      // Random soak against a FIFO scoreboard
      stalled = 1'b0;
      held_oh = '0;
      for (int n = 0; n < 300; n++) begin
         a_in_valid  = 1'($urandom_range(0, 1));
         a_in_index  = 2'($urandom_range(0, 3));
         a_out_ready = 1'($urandom_range(0, 1));
         if (a_in_valid && a_in_ready) begin
            w_push = 4'b0001 << a_in_index;
            q_exp.push_back(w_push);
         end
         if (a_out_valid && a_out_ready) begin
            if (q_exp.size() == 0) check("soak_extra", 1, 0);
            else                   check("soak_data", a_out_one_hot, q_exp.pop_front());
         end
         stalled = a_out_valid & ~a_out_ready;
         held_oh = a_out_one_hot;
         tick();
         if (stalled) begin
            check("soak_hold_v",  a_out_valid, 1);
            check("soak_hold_oh", a_out_one_hot, held_oh);
         end
      end
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      for (int n = 0; n < 4; n++) begin
         if (a_out_valid) begin
            if (q_exp.size() == 0) check("drain_extra", 1, 0);
            else                   check("drain_data", a_out_one_hot, q_exp.pop_front());
         end
         tick();
      end
      check("soak_left", q_exp.size(), 0);
      check("soak_idle", a_out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
